// File: rtl/sb_arbiter_if.sv
// sb_arbiter_if: bundles the two master request/response channels and the
// shared system-bus (sb) channel of the two-master arbiter.
//   m0_* / m1_* : address, request, write flag, write data from each master;
//                 grant, read data, response valid and error back to it.
//   sb_*        : address/request/write/write-data out to the slave;
//                 grant, read data, response valid and error back from it.
// Modports:
//   master : arbiter view (it is the bus master on the sb side)
//   slave  : environment view (core masters and the sb slave)
interface sb_arbiter_if;
    logic [31:0] m0_addr_in;
    logic        m0_req_in;
    logic        m0_wr_in;
    logic [31:0] m0_wdata_in;
    logic        m0_gnt_out;
    logic [31:0] m0_rdata_out;
    logic        m0_rvalid_out;
    logic        m0_err_out;

    logic [31:0] m1_addr_in;
    logic        m1_req_in;
    logic        m1_wr_in;
    logic [31:0] m1_wdata_in;
    logic        m1_gnt_out;
    logic [31:0] m1_rdata_out;
    logic        m1_rvalid_out;
    logic        m1_err_out;

    logic [31:0] sb_addr_out;
    logic        sb_req_out;
    logic        sb_wr_out;
    logic [31:0] sb_wdata_out;
    logic        sb_gnt_in;
    logic [31:0] sb_read_data_in;
    logic        sb_read_valid_in;
    logic        sb_err_in;

    modport master (
        input  m0_addr_in, m0_req_in, m0_wr_in, m0_wdata_in,
        output m0_gnt_out, m0_rdata_out, m0_rvalid_out, m0_err_out,
        input  m1_addr_in, m1_req_in, m1_wr_in, m1_wdata_in,
        output m1_gnt_out, m1_rdata_out, m1_rvalid_out, m1_err_out,
        output sb_addr_out, sb_req_out, sb_wr_out, sb_wdata_out,
        input  sb_gnt_in, sb_read_data_in, sb_read_valid_in, sb_err_in
    );

    modport slave (
        output m0_addr_in, m0_req_in, m0_wr_in, m0_wdata_in,
        input  m0_gnt_out, m0_rdata_out, m0_rvalid_out, m0_err_out,
        output m1_addr_in, m1_req_in, m1_wr_in, m1_wdata_in,
        input  m1_gnt_out, m1_rdata_out, m1_rvalid_out, m1_err_out,
        input  sb_addr_out, sb_req_out, sb_wr_out, sb_wdata_out,
        output sb_gnt_in, sb_read_data_in, sb_read_valid_in, sb_err_in
    );
endinterface

// File: rtl/sb_arbiter.sv
// sb_arbiter: two-master / one-slave arbiter for the CPU system bus.
// m0 (load/store) and m1 (instruction fetch) share one sb port; one
// transaction is outstanding at a time, responses go only to the owner,
// and a slave that stalls too long produces an error response.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : sb_arbiter_if.master (both master channels + sb channel)
//   owner_out  : current or last owner (0 = m0, 1 = m1)
//   busy_out   : high whenever a transaction is in progress
// Parameters:
//   PRIORITY_MODE  : 0 = round-robin, 1 = m0 always wins a tie
//   TIMEOUT_CYCLES : max cycles spent in ADDR+RESP before a forced error;
//                    0 disables the timeout
module sb_arbiter #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    sb_arbiter_if.master bus,
    output logic         owner_out,
    output logic         busy_out
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_wr;
    logic          r_owner;
    logic          r_last_owner;
    logic [CW-1:0] r_cnt;

    logic          w_any_req;
    logic          w_winner;
    logic          w_tmo_hit;
    logic          w_gnt;
    logic          w_rvalid;
    logic          w_err;
    logic [31:0]   w_rdata;

    assign w_any_req = bus.m0_req_in | bus.m1_req_in;
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST);

    // Winner selection: a lone requester always wins; a tie goes to m0 in
    // fixed-priority mode, otherwise to whoever did not own the bus last.
    always_comb begin
        w_winner = 1'b0;
        if (PRIORITY_MODE != 0) begin
            w_winner = !bus.m0_req_in;
        end else if (bus.m0_req_in && bus.m1_req_in) begin
            w_winner = !r_last_owner;
        end else begin
            w_winner = !bus.m0_req_in;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_any_req) w_next = ADDR;
            ADDR: begin
                // A grant in the expiry cycle beats the timeout.
                if (bus.sb_gnt_in)  w_next = RESP;
                else if (w_tmo_hit) w_next = ERR;
            end
            RESP: begin
                if (bus.sb_read_valid_in) w_next = IDLE;
                else if (w_tmo_hit)       w_next = ERR;
            end
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wr         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any_req) begin
                r_owner <= w_winner;
                r_addr  <= w_winner ? bus.m1_addr_in  : bus.m0_addr_in;
                r_wdata <= w_winner ? bus.m1_wdata_in : bus.m0_wdata_in;
                r_wr    <= w_winner ? bus.m1_wr_in    : bus.m0_wr_in;
                r_cnt   <= '0;
            end else if (r_state == ADDR || r_state == RESP) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == ADDR && bus.sb_gnt_in) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Response seen by the owner: forwarded slave response in RESP, or a
    // synthesised error with zero data in ERR. Stray slave responses in any
    // other state never reach a master.
    always_comb begin
        w_gnt    = (r_state == ADDR) && bus.sb_gnt_in;
        w_rvalid = 1'b0;
        w_err    = 1'b0;
        w_rdata  = '0;
        if (r_state == RESP && bus.sb_read_valid_in) begin
            w_rvalid = 1'b1;
            w_err    = bus.sb_err_in;
            w_rdata  = bus.sb_read_data_in;
        end else if (r_state == ERR) begin
            w_rvalid = 1'b1;
            w_err    = 1'b1;
        end
    end

    always_comb begin
        bus.m0_gnt_out    = w_gnt    && !r_owner;
        bus.m0_rvalid_out = w_rvalid && !r_owner;
        bus.m0_err_out    = w_err    && !r_owner;
        bus.m0_rdata_out  = r_owner ? '0 : w_rdata;
        bus.m1_gnt_out    = w_gnt    && r_owner;
        bus.m1_rvalid_out = w_rvalid && r_owner;
        bus.m1_err_out    = w_err    && r_owner;
        bus.m1_rdata_out  = r_owner ? w_rdata : '0;

        bus.sb_req_out   = (r_state == ADDR);
        bus.sb_addr_out  = (r_state == ADDR) ? r_addr  : '0;
        bus.sb_wdata_out = (r_state == ADDR) ? r_wdata : '0;
        bus.sb_wr_out    = (r_state == ADDR) && r_wr;
    end

    assign owner_out = r_owner;
    assign busy_out  = (r_state != IDLE);
endmodule

// File: tb/tb_sb_arbiter.sv
// tb_sb_arbiter: directed bench for sb_arbiter. dut0 is round-robin, dut1
// is fixed-priority; both use a 16-cycle timeout and share clk/rst.
module tb_sb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic owner0, busy0, owner1, busy1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sb_arbiter_if if0 ();
    sb_arbiter_if if1 ();

    sb_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .owner_out(owner0), .busy_out(busy0)
    );
    sb_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .owner_out(owner1), .busy_out(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        if0.m0_addr_in = '0; if0.m0_req_in = 1'b0; if0.m0_wr_in = 1'b0; if0.m0_wdata_in = '0;
        if0.m1_addr_in = '0; if0.m1_req_in = 1'b0; if0.m1_wr_in = 1'b0; if0.m1_wdata_in = '0;
        if0.sb_gnt_in = 1'b0; if0.sb_read_data_in = '0; if0.sb_read_valid_in = 1'b0; if0.sb_err_in = 1'b0;
        if1.m0_addr_in = '0; if1.m0_req_in = 1'b0; if1.m0_wr_in = 1'b0; if1.m0_wdata_in = '0;
        if1.m1_addr_in = '0; if1.m1_req_in = 1'b0; if1.m1_wr_in = 1'b0; if1.m1_wdata_in = '0;
        if1.sb_gnt_in = 1'b0; if1.sb_read_data_in = '0; if1.sb_read_valid_in = 1'b0; if1.sb_err_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        clr_inputs();
        do_reset();

        // Reset state
        #1;
        check("rst_busy",   32'(busy0), 32'd0);
        check("rst_owner",  32'(owner0), 32'd0);
        check("rst_sbreq",  32'(if0.sb_req_out), 32'd0);
        check("rst_sbaddr", if0.sb_addr_out, 32'd0);
        check("rst_m0gnt",  32'(if0.m0_gnt_out), 32'd0);
        check("rst_m1rv",   32'(if0.m1_rvalid_out), 32'd0);
        check("rst_busy1",  32'(busy1), 32'd0);

        // m1 read, addr 0x100, gnt immediately, valid 3 cycles after gnt
        if0.m1_req_in = 1'b1; if0.m1_addr_in = 32'h100;
        #1;
        check("rd_idle_sbreq", 32'(if0.sb_req_out), 32'd0);
        tick();
        if0.sb_gnt_in = 1'b1;
        #1;
        check("rd_sbreq",   32'(if0.sb_req_out), 32'd1);
        check("rd_sbaddr",  if0.sb_addr_out, 32'h100);
        check("rd_sbwr",    32'(if0.sb_wr_out), 32'd0);
        check("rd_m1gnt",   32'(if0.m1_gnt_out), 32'd1);
        check("rd_m0gnt",   32'(if0.m0_gnt_out), 32'd0);
        check("rd_owner",   32'(owner0), 32'd1);
        check("rd_busy",    32'(busy0), 32'd1);
        tick();
        if0.sb_gnt_in = 1'b0; if0.m1_req_in = 1'b0;
        #1;
        check("rd_resp_sbaddr", if0.sb_addr_out, 32'd0);
        check("rd_resp_sbreq",  32'(if0.sb_req_out), 32'd0);
        check("rd_resp_m1gnt",  32'(if0.m1_gnt_out), 32'd0);
        tick();
        #1;
        check("rd_wait_m1rv", 32'(if0.m1_rvalid_out), 32'd0);
        tick();
        if0.sb_read_valid_in = 1'b1; if0.sb_read_data_in = 32'hDEADBEEF;
        #1;
        check("rd_m1rv",    32'(if0.m1_rvalid_out), 32'd1);
        check("rd_m1rdata", if0.m1_rdata_out, 32'hDEADBEEF);
        check("rd_m1err",   32'(if0.m1_err_out), 32'd0);
        check("rd_m0rv",    32'(if0.m0_rvalid_out), 32'd0);
        check("rd_m0rdata", if0.m0_rdata_out, 32'd0);
        check("rd_busy_v",  32'(busy0), 32'd1);
        tick();
        if0.sb_read_valid_in = 1'b0; if0.sb_read_data_in = '0;
        #1;
        check("rd_end_busy",  32'(busy0), 32'd0);
        check("rd_end_m1rv",  32'(if0.m1_rvalid_out), 32'd0);
        check("rd_end_owner", 32'(owner0), 32'd1);

        // Tie from reset: dut0 alternates m0,m1,...; dut1 always m0
        do_reset();
        if0.m0_req_in = 1'b1; if0.m1_req_in = 1'b1;
        if1.m0_req_in = 1'b1; if1.m1_req_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if0.sb_gnt_in = 1'b1; if1.sb_gnt_in = 1'b1;
            #1;
            check("rr_m0gnt",  32'(if0.m0_gnt_out), 32'(i % 2 == 0));
            check("rr_m1gnt",  32'(if0.m1_gnt_out), 32'(i % 2 == 1));
            check("rr_owner",  32'(owner0), 32'(i % 2));
            check("pri_m0gnt", 32'(if1.m0_gnt_out), 32'd1);
            check("pri_m1gnt", 32'(if1.m1_gnt_out), 32'd0);
            tick();
            if0.sb_gnt_in = 1'b0; if1.sb_gnt_in = 1'b0;
            if0.sb_read_valid_in = 1'b1; if0.sb_read_data_in = 32'(i + 32'hA0);
            if1.sb_read_valid_in = 1'b1; if1.sb_read_data_in = 32'(i + 32'hB0);
            #1;
            if (i % 2 == 0) check("rr_rdata", if0.m0_rdata_out, 32'(i + 32'hA0));
            else            check("rr_rdata", if0.m1_rdata_out, 32'(i + 32'hA0));
            check("pri_m0rdata", if1.m0_rdata_out, 32'(i + 32'hB0));
            check("pri_m1rv",    32'(if1.m1_rvalid_out), 32'd0);
            tick();
            if0.sb_read_valid_in = 1'b0; if1.sb_read_valid_in = 1'b0;
        end
        clr_inputs();
        tick();

        // m0 write with error completion; input changes during ADDR ignored
        if0.m0_req_in = 1'b1; if0.m0_wr_in = 1'b1;
        if0.m0_addr_in = 32'h2000; if0.m0_wdata_in = 32'h000055AA;
        tick();
        if0.m0_addr_in = 32'h3333; if0.m0_wdata_in = 32'h12345678; if0.m0_wr_in = 1'b0;
        if0.sb_read_valid_in = 1'b1; if0.sb_read_data_in = 32'h99;
        #1;
        check("wr_sbwr",    32'(if0.sb_wr_out), 32'd1);
        check("wr_sbwdata", if0.sb_wdata_out, 32'h000055AA);
        check("wr_sbaddr",  if0.sb_addr_out, 32'h2000);
        check("wr_stray_rv", 32'(if0.m0_rvalid_out), 32'd0);
        check("wr_m0gnt0",  32'(if0.m0_gnt_out), 32'd0);
        tick();
        if0.sb_read_valid_in = 1'b0; if0.sb_gnt_in = 1'b1;
        #1;
        check("wr_m0gnt",   32'(if0.m0_gnt_out), 32'd1);
        tick();
        if0.sb_gnt_in = 1'b0; if0.m0_req_in = 1'b0;
        if0.sb_read_valid_in = 1'b1; if0.sb_err_in = 1'b1; if0.sb_read_data_in = 32'h77;
        #1;
        check("wr_sbwdata_resp", if0.sb_wdata_out, 32'd0);
        check("wr_m0rv",    32'(if0.m0_rvalid_out), 32'd1);
        check("wr_m0err",   32'(if0.m0_err_out), 32'd1);
        check("wr_m0rdata", if0.m0_rdata_out, 32'h77);
        tick();
        if0.sb_read_valid_in = 1'b0; if0.sb_err_in = 1'b0; if0.sb_read_data_in = '0;
        #1;
        check("wr_end_m0rv",  32'(if0.m0_rvalid_out), 32'd0);
        check("wr_end_m0err", 32'(if0.m0_err_out), 32'd0);

        // Timeout: slave never grants -> 16 cycles of sb_req, then ERR
        if0.m1_req_in = 1'b1; if0.m1_addr_in = 32'h300;
        tick();
        if0.m1_req_in = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!if0.sb_req_out) break;
            cnt++;
            tick();
        end
        check("tmo_reqcycles", 32'(cnt), 32'd16);
        check("tmo_m1rv",    32'(if0.m1_rvalid_out), 32'd1);
        check("tmo_m1err",   32'(if0.m1_err_out), 32'd1);
        check("tmo_m1rdata", if0.m1_rdata_out, 32'd0);
        check("tmo_m0rv",    32'(if0.m0_rvalid_out), 32'd0);
        check("tmo_busy",    32'(busy0), 32'd1);
        tick();
        if0.sb_read_valid_in = 1'b1; if0.sb_read_data_in = 32'h5A5A;
        #1;
        check("tmo_idle_busy", 32'(busy0), 32'd0);
        check("tmo_late_rv",   32'(if0.m1_rvalid_out), 32'd0);
        tick();
        if0.sb_read_valid_in = 1'b0; if0.sb_read_data_in = '0;

        // Grant in the 16th ADDR cycle beats the timeout
        if0.m1_req_in = 1'b1; if0.m1_addr_in = 32'h400;
        tick();
        if0.m1_req_in = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        if0.sb_gnt_in = 1'b1;
        #1;
        check("tmo16_sbreq", 32'(if0.sb_req_out), 32'd1);
        check("tmo16_m1gnt", 32'(if0.m1_gnt_out), 32'd1);
        check("tmo16_m1rv",  32'(if0.m1_rvalid_out), 32'd0);
        tick();
        if0.sb_gnt_in = 1'b0;
        if0.sb_read_valid_in = 1'b1; if0.sb_read_data_in = 32'hCAFE;
        #1;
        check("tmo16_rv",    32'(if0.m1_rvalid_out), 32'd1);
        check("tmo16_err",   32'(if0.m1_err_out), 32'd0);
        check("tmo16_rdata", if0.m1_rdata_out, 32'hCAFE);
        tick();
        if0.sb_read_valid_in = 1'b0; if0.sb_read_data_in = '0;

        // Reset during RESP, slave response arrives after release
        if0.m0_req_in = 1'b1; if0.m0_addr_in = 32'h500;
        tick();
        if0.sb_gnt_in = 1'b1;
        tick();
        if0.sb_gnt_in = 1'b0; if0.m0_req_in = 1'b0;
        #1;
        check("rstm_busy_resp", 32'(busy0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if0.sb_read_valid_in = 1'b1; if0.sb_read_data_in = 32'h1111;
        #1;
        check("rstm_m0rv",    32'(if0.m0_rvalid_out), 32'd0);
        check("rstm_m1rv",    32'(if0.m1_rvalid_out), 32'd0);
        check("rstm_m0rdata", if0.m0_rdata_out, 32'd0);
        check("rstm_busy",    32'(busy0), 32'd0);
        check("rstm_owner",   32'(owner0), 32'd0);
        check("rstm_sbreq",   32'(if0.sb_req_out), 32'd0);
        tick();
        #1;
        check("rstm_m0rv2",   32'(if0.m0_rvalid_out), 32'd0);
        check("rstm_busy2",   32'(busy0), 32'd0);
        if0.sb_read_valid_in = 1'b0; if0.sb_read_data_in = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sb_arbiter.md
Name: sb_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU system bus (sb).
- Shares the single sb port between the data (load/store) master m0 and the instruction-fetch master m1.
- Serialises transactions, returns each response only to the master that owns the bus, and converts slave stalls into error responses.
- Sits between the core's bus masters and the top-level sb interface; carries one outstanding transaction at a time.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins.
- TIMEOUT_CYCLES, 64, max cycles in ADDR+RESP before forced error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_addr_in  in  32  m0 address
- m0_req_in  in  1  m0 request; held until m0_gnt_out
- m0_wr_in  in  1  m0 write (1) / read (0)
- m0_wdata_in  in  32  m0 write data
- m0_gnt_out  out  1  m0 address accepted
- m0_rdata_out  out  32  m0 response data
- m0_rvalid_out  out  1  m0 response valid
- m0_err_out  out  1  m0 response error
- m1_addr_in, m1_req_in, m1_wr_in, m1_wdata_in, m1_gnt_out, m1_rdata_out, m1_rvalid_out, m1_err_out  same as m0, for m1
- sb_addr_out  out  32  bus address; 0 outside ADDR
- sb_req_out  out  1  bus request
- sb_wr_out  out  1  bus write
- sb_wdata_out  out  32  bus write data; 0 outside ADDR
- sb_gnt_in  in  1  slave accepted address
- sb_read_data_in  in  32  slave response data
- sb_read_valid_in  in  1  slave response valid; also the completion for writes
- sb_err_in  in  1  slave error, qualified by sb_read_valid_in
- owner_out  out  1  current or last owner (0 = m0, 1 = m1)
- busy_out  out  1  state != IDLE

Behaviour:
- States: IDLE, ADDR, RESP, ERR. Reset -> IDLE.
- All outputs reset to 0, except last_owner, which resets to 1 so m0 wins the first tie.
- IDLE: if any req is high, pick the winner, latch its addr/wr/wdata and owner, then go to ADDR.
  - Round-robin: on a tie, the winner is !last_owner; with a single request, that requester wins.
  - PRIORITY_MODE=1: m0 wins every tie.
- ADDR:
  - sb_req_out=1; sb_addr/wr/wdata driven from the latched values.
  - owner's mN_gnt_out = sb_gnt_in (combinational, same cycle).
  - On sb_gnt_in: go to RESP and update last_owner.
- RESP:
  - On sb_read_valid_in: in the same cycle, forward sb_read_data_in to the owner's rdata_out, assert its rvalid_out, and drive its err_out = sb_err_in.
  - Then go to IDLE. The next arbitration happens in IDLE, so there is one bubble cycle between transactions.
- ERR (single cycle):
  - Owner gets rvalid_out=1, err_out=1, rdata_out=0.
  - sb_req_out=0; then go to IDLE.
- Non-owner master outputs are always 0. rdata_out is 0 whenever rvalid_out=0.
- Latency:
  - req sampled in IDLE at cycle N -> sb_req_out=1 at N+1.
  - Minimum transaction: gnt at N+1, valid at N+2, next IDLE at N+3.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to ADDR; increments every cycle in ADDR/RESP.
  - When count == TIMEOUT_CYCLES-1 and no gnt (in ADDR) or valid (in RESP) arrives that cycle, go to ERR.
  - A completing event in the expiry cycle wins over the timeout.
- Request sampling:
  - Request fields are sampled only in IDLE.
  - Changes on m*_in after latching are ignored until the next IDLE.
  - A master dropping req before gnt does not abort the transaction.
- Stray sb_read_valid_in/sb_err_in in IDLE, ADDR or ERR is ignored and not forwarded.
- A late response after ERR is dropped.
- Reset mid-transaction: next cycle state=IDLE, all outputs 0; any in-flight slave response is ignored.

Test Plan:
- m1 read: m1_req addr 0x100, gnt same cycle as sb_req, valid+0xDEADBEEF 3 cycles later -> sb_addr_out=0x100 for 1 cycle; m1_gnt_out pulses 1 cycle; m1_rvalid_out pulses with 0xDEADBEEF; all m0 outputs 0; busy_out falls the cycle after valid.
- Tie after reset, PRIORITY_MODE=0, both masters re-request immediately after each response -> grant order m0, m1, m0, m1; owner_out alternates.
- PRIORITY_MODE=1, both masters held requesting -> m0 granted on 4 consecutive transactions; m1 starved.
- m0 write addr 0x2000 wdata 0x000055AA -> sb_wr_out=1 and sb_wdata_out=0x55AA during ADDR; completion with sb_err_in=1 -> m0_rvalid_out=1 and m0_err_out=1 for 1 cycle.
- TIMEOUT_CYCLES=16, slave never grants -> sb_req_out high for exactly 16 cycles, then ERR: m1_err_out=1, m1_rvalid_out=1, m1_rdata_out=0; IDLE the following cycle. Repeat with gnt in the 16th cycle -> normal RESP, no error.
- rst=1 during RESP, then sb_read_valid_in after reset release -> all outputs 0, no rvalid to either master, state IDLE.
